// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared state encoding, port ids and base address for dmem_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package dmem_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ACCESS  = 2'd1;
    localparam state_t ST_RESPOND = 2'd2;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam logic [31:0] DMEM_BASE_ADDR = 32'h1001_0000;

endpackage

`default_nettype wire

// File: rtl/dmem_rr_arbiter_2.sv
// ============================================================================
// Module   : dmem_rr_arbiter_2
// Brief    : Two-request round-robin picker holding the last-granted port.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_rr_arbiter_2
    import dmem_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    input  logic i_aReq,
    input  logic i_bReq,
    output logic o_grantValid,
    output logic o_grantPort
);

    logic r_lastGrant;

    always_comb begin
        o_grantValid = i_enable & (i_aReq | i_bReq);
        if (i_aReq & i_bReq) begin
            o_grantPort = ~r_lastGrant;
        end else if (i_bReq) begin
            o_grantPort = PORT_B;
        end else begin
            o_grantPort = PORT_A;
        end
    end

    // Starting from B makes A the winner of the first tie after reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lastGrant <= PORT_B;
        end else if (o_grantValid) begin
            r_lastGrant <= o_grantPort;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares a single-port data memory between two masters, one word
//            access per 3-cycle transaction, with base translation and checks.
// Revision : 1.0
// ============================================================================
`default_nettype none

module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          MEMORY_DEPTH = 1024,
    parameter logic [31:0] BASE_ADDR    = DMEM_BASE_ADDR,
    parameter int          MEM_ADDR_W   = $clog2(MEMORY_DEPTH)
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [31:0]           a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_ack,
    output logic                  a_err,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [31:0]           b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_ack,
    output logic                  b_err,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  busy,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [31:0] c_SPAN_BYTES = 32'(4 * MEMORY_DEPTH);

    state_t r_state;
    logic   r_we;
    logic   r_err;
    logic   r_port;

    logic                  w_idle;
    logic                  w_grantValid;
    logic                  w_grantPort;
    logic                  w_selWe;
    logic [31:0]           w_selAddr;
    logic [DATA_WIDTH-1:0] w_selWdata;
    logic [31:0]           w_off;
    logic                  w_addrErr;

    assign w_idle = (r_state == ST_IDLE);
    assign busy   = ~w_idle;

    dmem_rr_arbiter_2 u_rrArb (
        .clk          (clk),
        .reset        (reset),
        .i_enable     (w_idle),
        .i_aReq       (a_req),
        .i_bReq       (b_req),
        .o_grantValid (w_grantValid),
        .o_grantPort  (w_grantPort)
    );

    // Addresses below the base wrap to a huge offset and fail the range test.
    always_comb begin
        w_selWe    = (w_grantPort == PORT_B) ? b_we    : a_we;
        w_selAddr  = (w_grantPort == PORT_B) ? b_addr  : a_addr;
        w_selWdata = (w_grantPort == PORT_B) ? b_wdata : a_wdata;
        w_off      = w_selAddr - BASE_ADDR;
        w_addrErr  = (w_selAddr[1:0] != 2'b00) || (w_off >= c_SPAN_BYTES);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_we      <= 1'b0;
            r_err     <= 1'b0;
            r_port    <= PORT_A;
            a_ack     <= 1'b0;
            a_err     <= 1'b0;
            b_ack     <= 1'b0;
            b_err     <= 1'b0;
            rdata     <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    a_ack <= 1'b0;
                    a_err <= 1'b0;
                    b_ack <= 1'b0;
                    b_err <= 1'b0;
                    if (w_grantValid) begin
                        r_we      <= w_selWe;
                        r_err     <= w_addrErr;
                        r_port    <= w_grantPort;
                        mem_addr  <= w_off[MEM_ADDR_W+1:2];
                        mem_wdata <= w_selWdata;
                        mem_write <= w_selWe & ~w_addrErr;
                        mem_read  <= ~w_selWe & ~w_addrErr;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                    rdata     <= (!r_we && !r_err) ? mem_rdata : '0;
                    a_ack     <= (r_port == PORT_A);
                    a_err     <= (r_port == PORT_A) & r_err;
                    b_ack     <= (r_port == PORT_B);
                    b_err     <= (r_port == PORT_B) & r_err;
                    r_state   <= ST_RESPOND;
                end
                ST_RESPOND: begin
                    a_ack   <= 1'b0;
                    a_err   <= 1'b0;
                    b_ack   <= 1'b0;
                    b_err   <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                    a_ack     <= 1'b0;
                    a_err     <= 1'b0;
                    b_ack     <= 1'b0;
                    b_err     <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters:
  - port A: CPU load/store stage.
  - port B: a secondary master (DMA / memory-mapped IO engine).
- Latches one request at a time and performs a single word access.
- Returns the read data with a one-cycle ack pulse.
- Round-robin arbitration; MIPS data-segment base translation and range/alignment checking.

Parameters:
- DATA_WIDTH, 32, word width of requesters and memory.
- MEMORY_DEPTH, 1024, number of words in the data memory.
- BASE_ADDR, 32'h1001_0000, byte address mapped to memory word 0.
- MEM_ADDR_W, 10, memory word-index width, $clog2(MEMORY_DEPTH).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- a_req  input  1  port A request; sampled in IDLE.
- a_we  input  1  port A write enable (1 = store, 0 = load).
- a_addr  input  32  port A byte address.
- a_wdata  input  DATA_WIDTH  port A store data.
- a_ack  output  1  port A one-cycle completion pulse.
- a_err  output  1  port A error, valid with a_ack.
- b_req, b_we, b_addr, b_wdata  input  1/1/32/DATA_WIDTH  port B, same meaning as port A.
- b_ack, b_err  output  1/1  port B, same meaning as port A.
- rdata  output  DATA_WIDTH  load data for the acked port; valid while either ack is high.
- busy  output  1  high whenever state != IDLE.
- mem_write  output  1  memory write strobe.
- mem_read  output  1  memory read enable.
- mem_addr  output  MEM_ADDR_W  memory word index.
- mem_wdata  output  DATA_WIDTH  memory write data.
- mem_rdata  input  DATA_WIDTH  memory read data, combinational from mem_addr/mem_read.

Behaviour:
- Reset values: state=IDLE, last_grant=B, all acks/errs=0, rdata=0, busy=0, mem_write=0, mem_read=0, mem_addr=0, mem_wdata=0.
- States: IDLE -> ACCESS -> RESPOND -> IDLE. Fixed 3 cycles per transaction.
- IDLE:
  - Only A requests: grant A. Only B requests: grant B.
  - Both request: grant the port that is not last_grant. A wins the first tie after reset.
  - On grant, latch we, addr, wdata and the granted-port id. Update last_grant. Go to ACCESS.
  - No request: stay in IDLE; all mem strobes are 0.
- Address check, done at latch time:
  - off = addr - BASE_ADDR, 32-bit unsigned.
  - err_l = (addr[1:0] != 0) OR (off >= 4*MEMORY_DEPTH). Addresses below BASE_ADDR wrap to a large off and fail the check.
  - Word index = off[MEM_ADDR_W+1:2].
- ACCESS (one cycle):
  - mem_addr = latched word index; mem_wdata = latched wdata.
  - mem_write = we_l & ~err_l; mem_read = ~we_l & ~err_l.
  - At the closing edge: memory performs the write; rdata <= mem_rdata if load and no error, else rdata <= 0.
- RESPOND (one cycle):
  - Ack of the granted port = 1; its err = err_l. Other port's ack = 0.
  - mem strobes = 0. Next state is IDLE.
- mem_addr/mem_wdata hold the last values outside ACCESS; strobes are the only qualifiers.
- Request hold rules:
  - A requester need not hold its signals after the IDLE sampling edge.
  - Dropping req mid-transaction does not cancel it.
  - req still high in the IDLE cycle after ack is treated as a new transaction.
- Worst-case wait with both ports saturated: 6 cycles from req to ack. No starvation.
- Acks are never simultaneous. Exactly one ack per granted transaction.
- Errored access: no memory strobe, rdata=0, ack with err=1, arbitration still rotates.
- Reset mid-operation:
  - Asynchronous return to IDLE; outputs go to reset values immediately.
  - A write in ACCESS is suppressed because mem_write is forced low.
  - The pending transaction is dropped with no ack; requesters re-issue after reset.
- All address arithmetic is 32-bit; mem_addr is a truncation of off[MEM_ADDR_W+1:2]. There is no further wrap.

Decomposition:
- Shared package dmem_pkg holds:
  - State encoding localparams: ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_RESPOND=2'd2.
  - PORT_A=1'b0, PORT_B=1'b1.
  - DMEM_BASE_ADDR=32'h1001_0000.
- One natural sub-module: dmem_rr_arbiter_2, the two-request round-robin picker with its last_grant register.
- Address check and translation stay inline.

Test Plan:
- A store/load:
  - Stimulus: a_req, a_we=1, a_addr=32'h1001_0008, a_wdata=32'hDEADBEEF; then a load from the same address.
  - Required: mem_write pulses with mem_addr=2; a_ack 2 cycles after the sampling edge, a_err=0; load returns rdata=32'hDEADBEEF; busy high for 2 cycles each.
- Contention:
  - Stimulus: a_req and b_req held high continuously from reset.
  - Required: grant order A, B, A, B; acks alternate every 3 cycles; never both acks high.
- Error cases:
  - Stimulus: a_addr=32'h1001_0002 (misaligned); b_addr=32'h1001_1000 (off = 4096 = 4*1024); a_addr=32'h1000_FFFC (below base).
  - Required: each acked with err=1, rdata=0, mem_write=0 and mem_read=0 throughout.
- Boundary:
  - Stimulus: store to 32'h1001_0FFC.
  - Required: mem_addr=1023, err=0.
- Request dropped early:
  - Stimulus: b_req high for one IDLE cycle only, load from 32'h1001_0004 preloaded with 32'h12345678.
  - Required: b_ack still pulses 2 cycles later with rdata=32'h12345678.
- Reset mid-op:
  - Stimulus: assert reset during ACCESS of an A store.
  - Required: mem_write drops immediately, no a_ack, the memory word is unchanged, state=IDLE; first transaction after reset completes normally.
